// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the contending sources and the shared-selector arbiter.
interface mux_sel_arbiter_if #(
  parameter int N_REQ = 16,
  parameter int SEL_W = 4
);
  logic [N_REQ-1:0] req_i;
  logic             done_i;
  logic [SEL_W-1:0] sel_o;
  logic [N_REQ-1:0] gnt_o;
  logic             valid_o;
  logic             timeout_o;

  // arbiter side
  modport slave (
    input  req_i, done_i,
    output sel_o, gnt_o, valid_o, timeout_o
  );

  // requester side
  modport master (
    output req_i, done_i,
    input  sel_o, gnt_o, valid_o, timeout_o
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter owning the select of a shared 16:1 read path.
// A tenure ends on done, on the holder dropping its request, or after
// MAX_HOLD cycles; a waiting requester is granted on the very next cycle.
module mux_sel_arbiter #(
  parameter int N_REQ    = 16,
  parameter int SEL_W    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  mux_sel_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] LAST = 8'(MAX_HOLD - 1);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [7:0]       cnt;
  logic [SEL_W-1:0] sel_q;
  logic [N_REQ-1:0] gnt_q;
  logic             valid_q;
  logic             timeout_q;

  logic [SEL_W-1:0] win;
  logic             win_vld;
  logic [SEL_W-1:0] idx;
  logic             holder_req;
  logic             at_limit;
  logic             rel;
  logic             forced_only;

  // Rotating first-set scan starting at ptr; index arithmetic wraps in SEL_W bits.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + SEL_W'(i);
      if (!win_vld && bus.req_i[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end

  // Release causes; a timeout is reported only when the hold limit alone ends the tenure.
  always_comb begin
    holder_req  = bus.req_i[sel_q];
    at_limit    = (cnt == LAST);
    rel         = bus.done_i || !holder_req || at_limit;
    forced_only = at_limit && !bus.done_i && holder_req;
  end

  // Arbiter FSM with registered grant outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      sel_q     <= '0;
      gnt_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            state   <= GRANT;
            sel_q   <= win;
            gnt_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
            valid_q <= 1'b1;
            cnt     <= '0;
            ptr     <= win + 1'b1;
          end
        end
        GRANT: begin
          if (rel) begin
            timeout_q <= forced_only;
            // ptr already points past the holder, so it has lowest priority here
            if (win_vld) begin
              sel_q   <= win;
              gnt_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
              cnt     <= '0;
              ptr     <= win + 1'b1;
            end else begin
              state   <= IDLE;
              gnt_q   <= '0;
              valid_q <= 1'b0;
            end
          end else if (cnt != LAST) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel_o     = sel_q;
  assign bus.gnt_o     = gnt_q;
  assign bus.valid_o   = valid_q;
  assign bus.timeout_o = timeout_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed + random bench for mux_sel_arbiter against a rule-level reference model.
module tb_mux_sel_arbiter;
  localparam int MH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mux_sel_arbiter_if #(.N_REQ(16), .SEL_W(4)) bus();

  mux_sel_arbiter #(.N_REQ(16), .SEL_W(4), .MAX_HOLD(MH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: holder index (-1 when idle), last select, pointer, tenure length.
  int m_hold = -1;
  int m_sel  = 0;
  int m_ptr  = 0;
  int m_cnt  = 0;
  bit m_to   = 1'b0;

  function automatic int pick(logic [15:0] r, int p);
    for (int k = 0; k < 16; k++) begin
      int j;
      j = (p + k) % 16;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_hold = -1; m_sel = 0; m_ptr = 0; m_cnt = 0; m_to = 1'b0;
  endtask

  task automatic model_grant(int w);
    m_hold = w; m_sel = w; m_cnt = 0; m_ptr = (w + 1) % 16;
  endtask

  task automatic model_step(logic [15:0] r, logic d);
    int w;
    bit rd, ra, rf;
    if (m_hold < 0) begin
      m_to = 1'b0;
      w = pick(r, m_ptr);
      if (w >= 0) model_grant(w);
    end else begin
      rd = d;
      ra = !r[m_hold];
      rf = (m_cnt == MH - 1);
      if (rd || ra || rf) begin
        m_to = rf && !rd && !ra;
        w = pick(r, m_ptr);
        if (w >= 0) model_grant(w);
        else m_hold = -1;
      end else begin
        m_to = 1'b0;
        if (m_cnt < MH - 1) m_cnt++;
      end
    end
  endtask

  task automatic check(string tag);
    logic [15:0] eg;
    logic        ev;
    eg = (m_hold >= 0) ? (16'd1 << m_hold) : 16'h0;
    ev = (m_hold >= 0);
    n_checks++;
    assert (bus.valid_o === ev) else begin
      n_fails++; $error("FAIL %s valid: got %b expected %b", tag, bus.valid_o, ev);
    end
    n_checks++;
    assert (bus.sel_o === 4'(m_sel)) else begin
      n_fails++; $error("FAIL %s sel: got %0d expected %0d", tag, bus.sel_o, m_sel);
    end
    n_checks++;
    assert (bus.gnt_o === eg) else begin
      n_fails++; $error("FAIL %s gnt: got %h expected %h", tag, bus.gnt_o, eg);
    end
    n_checks++;
    assert (bus.timeout_o === m_to) else begin
      n_fails++; $error("FAIL %s timeout: got %b expected %b", tag, bus.timeout_o, m_to);
    end
  endtask

  // Independent constant check of the active holder.
  task automatic expect_sel(int s, string tag);
    n_checks++;
    assert (bus.valid_o === 1'b1 && bus.sel_o === 4'(s)) else begin
      n_fails++; $error("FAIL %s: got valid=%b sel=%0d expected valid=1 sel=%0d", tag, bus.valid_o, bus.sel_o, s);
    end
  endtask

  task automatic expect_bit(logic obs, logic exp, string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++; $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, model the coming edge, sample 1ns after it.
  task automatic cyc(logic [15:0] r, logic d, string tag);
    @(negedge clk);
    bus.req_i  = r;
    bus.done_i = d;
    model_step(r, d);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req_i  = '0;
    bus.done_i = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] rq;
    bus.req_i  = '0;
    bus.done_i = 1'b0;
    #2;
    check("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // basic grant and done release
    cyc(16'h0001, 1'b0, "basic_e1");
    expect_sel(0, "basic_grant");
    cyc(16'h0001, 1'b0, "basic_e2");
    cyc(16'h0001, 1'b0, "basic_e3");
    cyc(16'h0000, 1'b1, "basic_e4");
    expect_bit(bus.valid_o, 1'b0, "basic_idle");

    // fairness from a fresh pointer
    do_reset();
    for (int k = 0; k < 17; k++) begin
      cyc(16'hFFFF, 1'b1, "fair");
      expect_sel(k % 16, "fair_order");
    end

    // pointer wrap: grant 13 then 14, 0, 3
    cyc(16'h0000, 1'b1, "wrap_idle");
    cyc(16'h2000, 1'b0, "wrap_13");
    expect_sel(13, "wrap_13");
    cyc(16'h4009, 1'b1, "wrap_a");
    expect_sel(14, "wrap_14");
    cyc(16'h4009, 1'b1, "wrap_b");
    expect_sel(0, "wrap_0");
    cyc(16'h4009, 1'b1, "wrap_c");
    expect_sel(3, "wrap_3");

    // hold limit on a sole requester
    cyc(16'h0000, 1'b0, "to_idle");
    cyc(16'h0020, 1'b0, "to_grant");
    expect_sel(5, "to_grant");
    for (int k = 0; k < 7; k++) begin
      cyc(16'h0020, 1'b0, "to_hold");
      expect_bit(bus.timeout_o, 1'b0, "to_hold_quiet");
    end
    cyc(16'h0020, 1'b0, "to_fire");
    expect_bit(bus.timeout_o, 1'b1, "to_pulse");
    expect_sel(5, "to_regrant");

    // done coincides with the limit: normal release
    for (int k = 0; k < 7; k++) cyc(16'h0020, 1'b0, "sim_hold");
    cyc(16'h0020, 1'b1, "sim_done");
    expect_bit(bus.timeout_o, 1'b0, "sim_no_pulse");

    // holder drops while requester 9 waits
    cyc(16'h0004, 1'b0, "drop_2");
    expect_sel(2, "drop_2");
    cyc(16'h0200, 1'b0, "drop_9");
    expect_sel(9, "drop_9");

    // asynchronous reset mid-grant
    cyc(16'h0000, 1'b0, "ar_idle");
    cyc(16'h0080, 1'b0, "ar_grant");
    expect_sel(7, "ar_grant");
    cyc(16'h0080, 1'b0, "ar_hold");
    #2;
    rst_n = 1'b0;
    bus.req_i = '0;
    model_reset();
    #1;
    check("ar_async");
    expect_bit(bus.valid_o, 1'b0, "ar_valid_zero");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(16'h0180, 1'b0, "ar_first");
    expect_sel(7, "ar_first");

    // random phase: requests persist for a while, done occasionally
    rq = 16'h0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0)
        rq = 16'($urandom) & 16'($urandom) & 16'($urandom);
      cyc(rq, ($urandom_range(0, 3) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Round-robin arbiter with a registered grant. Shares one 16-way 32-bit read path among 16 requesters.
- Drives the 4-bit select of the shared 16:1 selector, plus a one-hot grant vector.
- Holds a grant until the holder signals done, drops its request, or exceeds a hold limit.
- Used in the pipeline wherever several sources (debug/CSR/forwarding taps) contend for one shared selector.

Parameters:
- N_REQ, 16, number of requesters; fixed at 16 to match the 4-bit select.
- SEL_W, 4, select width; must equal log2(N_REQ).
- MAX_HOLD, 8, maximum GRANT cycles per tenure before forced release; legal range 2..255.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- req_i  input  16  request vector; bit k is requester k.
- done_i  input  1  current holder finished; sampled only in GRANT.
- sel_o  output  4  select for the shared 16:1 selector; index of the current holder.
- gnt_o  output  16  one-hot grant; all zero when idle.
- valid_o  output  1  a grant is active; sel_o is meaningful.
- timeout_o  output  1  one-cycle pulse on a forced release by the hold limit.

Behaviour:
- One clock. Reset is asynchronous and active-low (rst_ni).
- Reset values:
  - state=IDLE; sel_o=0; gnt_o=0; valid_o=0; timeout_o=0.
  - Priority pointer ptr=0; hold counter cnt=0.
- Reset asserted mid-grant clears everything immediately, with no clock needed. The first arbitration after reset starts from requester 0.
- Arbitration (combinational, internal only):
  - winner = first set bit of req_i scanning ptr, ptr+1, …, 15, 0, …, ptr-1 (mod 16).
  - No set bit means no winner.
- State IDLE:
  - A winner exists at edge n → GRANT at n+1.
  - Then sel_o=winner, gnt_o=1<<winner, valid_o=1, cnt=0, ptr=winner+1 mod 16 (15 wraps to 0).
  - Latency: request visible at edge n gives a grant visible in cycle n+1.
- State GRANT: a release occurs at an edge when any of the following holds:
  - (a) done_i=1;
  - (b) req_i[sel_o]=0 (holder abandons);
  - (c) cnt==MAX_HOLD-1 (forced).
- No release at an edge: hold sel_o/gnt_o; cnt increments (saturates at MAX_HOLD-1).
- Release with a winner present in the same cycle → back-to-back grant to that winner next cycle; no IDLE bubble.
  - The arbitration uses the already-advanced ptr, so the old holder has lowest priority.
  - The old holder can win again only if it is the sole requester.
- Release with no winner → IDLE; gnt_o=0, valid_o=0, sel_o keeps its last value.
- timeout_o:
  - Asserted for exactly the cycle after a release caused only by (c).
  - If (a) or (b) coincides with (c), the release counts as normal and timeout_o=0.
- done_i outside GRANT is ignored. req_i changes of non-holders never disturb an active grant.
- gnt_o is always one-hot or zero. sel_o == index of the gnt_o bit whenever valid_o=1.
- All outputs are registered; no combinational path from req_i/done_i to outputs.

Test Plan:
- Reset, then req_i=16'h0001 at edge 1 → cycle 2: valid_o=1, sel_o=0, gnt_o=16'h0001. done_i=1 at edge 4 → cycle 5: valid_o=0, gnt_o=0.
- Fairness: req_i=16'hFFFF held, done_i=1 every GRANT cycle → grants 0,1,2,…,15,0 on consecutive cycles, with no idle gaps.
- Pointer wrap: ptr=14 (after a grant to 13), req_i=16'h4009 → grants in order 14, 0, 3.
- Timeout: req_i=16'h0020 held, done_i=0, MAX_HOLD=8 → sel_o=5 for exactly 8 cycles, then timeout_o=1 for one cycle. Because the holder is the sole requester, it is re-granted with cnt=0.
- Simultaneous events:
  - done_i=1 on the cycle cnt==MAX_HOLD-1 → release with timeout_o=0.
  - Holder drops req_i with req_i[9]=1 also pending → next cycle sel_o=9.
- Async reset mid-grant (sel_o=7): assert rst_ni=0 between edges → outputs zero immediately. After release with req_i=16'h0180, the first grant goes to requester 7 (ptr back to 0).
